uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive byte buffer directly downstream of the UART receiver top level.
- Captures each completed receive byte on the receiver's done pulse and discards frames the receiver flags as errored.
- Holds accepted bytes in a circular FIFO until the consumer (CPU/bus side) pops them, and reports fill level, overflow and dropped-frame statistics.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two, at least 2
DATA_W, 8, width of one stored byte
CNT_W, $clog2(DEPTH)+1, width of the fill-level output (derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
soft_rst  input  1  synchronous active-high clear, same effect as rst but applied on the clock edge
wr_valid  input  1  single-cycle pulse from receiver rx_done
wr_data  input  DATA_W  byte from receiver rx_data_out, sampled when wr_valid=1
wr_error  input  1  receiver error flag, sampled when wr_valid=1
rd_en  input  1  pop request from consumer
rd_data  output  DATA_W  popped byte, registered
rd_valid  output  1  one-cycle pulse, rd_data is valid this cycle
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  CNT_W  current number of stored entries, 0..DEPTH
overflow  output  1  sticky: a good byte was lost because the FIFO was full
drop_count  output  8  number of errored frames discarded, saturates at 255

Behaviour:
- Reset (rst=0, async) or soft_rst=1 (sync): pointers=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, drop_count=0. Memory contents are don't-care. soft_rst overrides all same-cycle reads and writes.
- Write acceptance:
  - wr_valid=1, wr_error=0, and (not full, or a read is accepted the same cycle): store wr_data at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - wr_valid=1, wr_error=1: byte is not stored; drop_count += 1, held at 255. Does not affect overflow.
  - wr_valid=1, wr_error=0, full=1, no accepted read: byte is dropped; overflow set to 1 and held until reset/soft_rst.
- Read acceptance:
  - rd_en=1 and empty=0: entry at rd_ptr is driven to rd_data on the next edge, rd_valid=1 for exactly that cycle, rd_ptr wraps DEPTH-1 -> 0.
  - Read latency is 1 cycle from the accepting edge.
  - rd_en=1 while empty: ignored, rd_valid stays 0, rd_data holds its last value. There is no fall-through: a same-cycle write into an empty FIFO is not readable until the following cycle.
- Simultaneous accepted read and write: count is unchanged. When full, both are accepted and there is no overflow.
- count, empty and full are registered and updated on the same edge as the pointers. full = (count==DEPTH), empty = (count==0).
- Pointers are $clog2(DEPTH) bits wide; count is tracked explicitly (no extra pointer MSB).
- rd_data is held between pops. rd_valid is strictly a pulse.
- No state machine beyond the pointer/count datapath. Control is a priority decode: soft_rst > accepted write/read combination.

Decomposition:
- Shared package: none required. DEPTH power-of-two check is an elaboration-time assertion local to the module.
- One natural sub-module: fifo_mem, a DEPTH x DATA_W dual-port register array with one synchronous write port and one registered read port. Pointer/count/flag logic stays in uart_rx_fifo.

Test Plan:
- Reset/basic: release rst, push 0xA5 then 0x3C, pulse rd_en twice -> rd_data 0xA5 then 0x3C with rd_valid one cycle after each rd_en; count 2 -> 0; empty=1 at end.
- Fill/overflow: DEPTH=16, push 0x00..0x0F -> full=1, count=16; push 0xFF -> overflow=1, count stays 16; drain 16 -> data 0x00..0x0F in order, 0xFF never appears, overflow still 1.
- Wrap and simultaneous: push 10, pop 10, then push 12 -> pointers wrap past 15 and data order is preserved. With full=1, assert wr_valid(0x77) and rd_en in the same cycle -> count stays 16, no overflow, 0x77 emerges last.
- Error frames: 3 pulses with wr_error=1 -> drop_count=3, count=0, empty=1. Force 300 errored pulses -> drop_count=255.
- Empty read/soft_rst: rd_en while empty -> rd_valid=0 and rd_data unchanged. Push 5 bytes with overflow set, assert soft_rst -> next cycle count=0, empty=1, overflow=0, drop_count=0.
- Async reset mid-operation: assert rst low between clock edges while count=7 -> all outputs go to reset values immediately without a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
// Frame-drop statistics are an 8-bit saturating counter.
package uart_rx_fifo_pkg;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one registered read port.
// The read register is cleared by reset/clr and otherwise holds its value between reads.
module uart_rx_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the pre-write contents, so a same-address read/write while full returns the old entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: stores good frames, drops errored ones,
// and reports fill level, sticky overflow and a saturating dropped-frame count.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_rst,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_error,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_acc;
    logic             wr_acc;
    logic             wr_lost;
    logic             wr_drop;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        rd_acc  = rd_en && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
        wr_acc  = wr_valid && !wr_error && (!full || rd_acc);
        wr_lost = wr_valid && !wr_error && full && !rd_acc;
        wr_drop = wr_valid && wr_error;

        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (soft_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == CNT_W'(DEPTH));
            rd_valid <= rd_acc;
            if (wr_lost) begin
                overflow <= 1'b1;
            end
            if (wr_drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .clr     (soft_rst),
        .wr_en   (wr_acc && !soft_rst),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed and random traffic compared
// against a queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              soft_rst;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_error;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [4:0]        count;
    logic              overflow;
    logic [7:0]        drop_count;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_error   (wr_error),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_overflow;
    int         m_drops;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_overflow = 1'b0;
        m_drops    = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":rd_valid"},   32'(rd_valid),   32'(m_rd_valid));
        chk({ctx, ":rd_data"},    32'(rd_data),    32'(m_rd_data));
        chk({ctx, ":count"},      32'(count),      32'(q.size()));
        chk({ctx, ":empty"},      32'(empty),      32'(q.size() == 0));
        chk({ctx, ":full"},       32'(full),       32'(q.size() == DEPTH));
        chk({ctx, ":overflow"},   32'(overflow),   32'(m_overflow));
        chk({ctx, ":drop_count"}, 32'(drop_count), 32'(m_drops));
    endtask

    // One clock: drive inputs, advance the model by the receive-buffer rules, check after the edge.
    task automatic step(input string ctx, input bit wv, input logic [7:0] wd,
                        input bit we, input bit re, input bit sr);
        bit was_full;
        bit did_read;
        wr_valid = wv;
        wr_data  = wd;
        wr_error = we;
        rd_en    = re;
        soft_rst = sr;
        if (sr) begin
            model_clear();
        end else begin
            was_full   = (q.size() == DEPTH);
            did_read   = re && (q.size() > 0);
            m_rd_valid = did_read;
            if (did_read) m_rd_data = q.pop_front();
            if (wv && we) begin
                if (m_drops < 255) m_drops++;
            end else if (wv) begin
                if (!was_full || did_read) q.push_back(wd);
                else m_overflow = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        soft_rst = 1'b0;
        wr_error = 1'b0;
        check_all(ctx);
    endtask

    initial begin
        rst      = 1'b0;
        soft_rst = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_error = 1'b0;
        rd_en    = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Basic push/pop
        step("basic_w1", 1, 8'hA5, 0, 0, 0);
        step("basic_w2", 1, 8'h3C, 0, 0, 0);
        step("basic_r1", 0, 8'h00, 0, 1, 0);
        chk("basic_first", 32'(rd_data), 32'h0A5);
        step("basic_r2", 0, 8'h00, 0, 1, 0);
        chk("basic_second", 32'(rd_data), 32'h03C);
        step("basic_idle", 0, 8'h00, 0, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        step("ovf_push", 1, 8'hFF, 0, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 8'h00, 0, 1, 0);
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        step("drain_idle", 0, 8'h00, 0, 1, 0);

        // Wrap and simultaneous read/write while full
        step("clr1", 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("wrap_w", 1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) step("wrap_r", 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) step("wrap_w2", 1, 8'($urandom), 0, 0, 0);
        step("simul", 1, 8'h77, 0, 1, 0);
        chk("simul_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step("simul_drain", 0, 8'h00, 0, 1, 0);
        chk("simul_last", 32'(rd_data), 32'h077);

        // Errored frames and drop_count saturation
        for (int i = 0; i < 3; i++) step("err3", 1, 8'($urandom), 1, 0, 0);
        for (int i = 0; i < 300; i++) step("err300", 1, 8'($urandom), 1, 0, 0);
        chk("drop_sat", 32'(drop_count), 32'd255);

        // Empty read holds rd_data
        step("clr2", 0, 8'h00, 0, 0, 1);
        step("er_w", 1, 8'h5A, 0, 0, 0);
        step("er_r", 0, 8'h00, 0, 1, 0);
        step("er_empty", 0, 8'h00, 0, 1, 0);
        chk("er_hold", 32'(rd_data), 32'h05A);
        step("er_nofall", 1, 8'h11, 0, 1, 0);
        chk("er_nofall_valid", 32'(rd_valid), 32'd0);
        step("er_pop", 0, 8'h00, 0, 1, 0);

        // soft_rst with stored data, overflow and drops, overriding same-cycle traffic
        for (int i = 0; i < DEPTH + 1; i++) step("sr_fill", 1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 11; i++) step("sr_drain", 0, 8'h00, 0, 1, 0);
        step("sr_err", 1, 8'h00, 1, 0, 0);
        step("sr_apply", 1, 8'h99, 0, 1, 1);
        chk("sr_count", 32'(count), 32'd0);

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++) step("ar_fill", 1, 8'($urandom), 0, 0, 0);
        step("ar_read", 1, 8'h42, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic: first biased toward filling, then toward draining
        for (int i = 0; i < 400; i++) begin
            bit wv;
            bit re;
            if (i < 200) begin
                wv = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 2) == 0);
            end else begin
                wv = ($urandom_range(0, 2) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            step("rand", wv, 8'($urandom), ($urandom_range(0, 7) == 0), re,
                 ($urandom_range(0, 127) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
